// File: rtl/onehot_to_bin_stream.sv
// One-hot to binary encoder with a 2-entry output queue and error flagging (optional counter: ONEHOT_TO_BIN_ERR_CNT_EN).
// Latency: a word accepted at edge N appears at the head (valid_o=1) during cycle N+1; no input-to-output comb path.
// Backpressure: ready_o is registered (fill count < 2); while full, valid_i is ignored and the word must be held upstream.
module onehot_to_bin_stream #(
    parameter int ONEHOT_WIDTH = 8,
    parameter int BIN_WIDTH    = $clog2(ONEHOT_WIDTH),
    parameter int CNT_WIDTH    = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [ONEHOT_WIDTH-1:0] onehot_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    output logic [BIN_WIDTH-1:0]    bin_o,
    output logic                    zero_o,
    output logic                    multi_o,
    output logic                    valid_o,
    input  logic                    ready_i,
    input  logic                    clr_i,
    output logic                    err_sticky_o,
    output logic [CNT_WIDTH-1:0]    err_cnt_o
);

    // One queue slot: encoded index plus the two error qualifiers.
    typedef struct packed {
        logic [BIN_WIDTH-1:0] bin;
        logic                 zero;
        logic                 multi;
    } entry_t;

    entry_t     enc;
    entry_t     head_q, head_d;
    entry_t     tail_q, tail_d;
    logic [1:0] cnt_q, cnt_d;
    logic       err_sticky_q, err_sticky_d;
    logic       push;
    logic       pop;
    logic       err_push;

    // Encode the incoming word: lowest set bit wins, zero and multi-hot flagged.
    always_comb begin
        enc       = '0;
        enc.zero  = (onehot_i == '0);
        // Clearing the lowest set bit leaves something only if two or more were set.
        enc.multi = ((onehot_i & (onehot_i - ONEHOT_WIDTH'(1))) != '0);
        for (int i = ONEHOT_WIDTH - 1; i >= 0; i--) begin
            if (onehot_i[i]) begin
                enc.bin = BIN_WIDTH'(i);
            end
        end
    end

    // Handshake qualifiers; ready/valid come straight from the fill count flop.
    always_comb begin
        ready_o  = (cnt_q < 2'd2);
        valid_o  = (cnt_q != 2'd0);
        push     = valid_i && ready_o;
        pop      = valid_o && ready_i;
        err_push = push && (enc.zero || enc.multi);
    end

    // Queue update: head slot always drives the outputs, tail slot backs it up.
    always_comb begin
        cnt_d  = cnt_q;
        head_d = head_q;
        tail_d = tail_q;
        case ({push, pop})
            2'b10: begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd0) begin
                    head_d = enc;
                end else begin
                    tail_d = enc;
                end
            end
            2'b01: begin
                cnt_d = cnt_q - 2'd1;
                // Draining to empty leaves the old head in place, so outputs hold.
                if (cnt_q == 2'd2) begin
                    head_d = tail_q;
                end
            end
            2'b11: begin
                // Only reachable with one entry: the new word replaces the departing head.
                head_d = enc;
            end
            default: begin
            end
        endcase
    end

    // Sticky error: clear first so a simultaneous error push still sets it.
    always_comb begin
        err_sticky_d = err_sticky_q;
        if (clr_i) begin
            err_sticky_d = 1'b0;
        end
        if (err_push) begin
            err_sticky_d = 1'b1;
        end
    end

    // Queue and sticky-flag registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q        <= 2'd0;
            head_q       <= '0;
            tail_q       <= '0;
            err_sticky_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    assign bin_o        = head_q.bin;
    assign zero_o       = head_q.zero;
    assign multi_o      = head_q.multi;
    assign err_sticky_o = err_sticky_q;

`ifdef ONEHOT_TO_BIN_ERR_CNT_EN
    logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

    // Saturating error count; a clear coinciding with an error push restarts at 1.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (clr_i) begin
            err_cnt_d = '0;
        end
        if (err_push) begin
            if (clr_i) begin
                err_cnt_d = CNT_WIDTH'(1);
            end else if (err_cnt_q != {CNT_WIDTH{1'b1}}) begin
                err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    // Error counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt_o = err_cnt_q;
`else
    assign err_cnt_o = '0;
`endif

endmodule

// File: tb/tb_onehot_to_bin_stream.sv
// Randomised and directed stimulus against a queue-based reference model.
// Model is updated at each falling edge from the inputs that the next rising edge will sample.
// Checks every cycle: handshake, head contents, sticky flag and error counter.
module tb_onehot_to_bin_stream;

    localparam int OW     = 8;
    localparam int BW     = 3;
    localparam int CW     = 8;
    localparam int CNTMAX = (1 << CW) - 1;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [OW-1:0] onehot_i;
    logic          valid_i;
    logic          ready_o;
    logic [BW-1:0] bin_o;
    logic          zero_o;
    logic          multi_o;
    logic          valid_o;
    logic          ready_i;
    logic          clr_i;
    logic          err_sticky_o;
    logic [CW-1:0] err_cnt_o;

    onehot_to_bin_stream #(.ONEHOT_WIDTH(OW), .CNT_WIDTH(CW)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .onehot_i    (onehot_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .bin_o       (bin_o),
        .zero_o      (zero_o),
        .multi_o     (multi_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .clr_i       (clr_i),
        .err_sticky_o(err_sticky_o),
        .err_cnt_o   (err_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int bin;
        bit zero;
        bit multi;
    } ent_t;

    ent_t exp_q[$];
    ent_t last_head;
    bit   m_sticky;
    int   m_cnt;
    bit   model_ok = 1'b0;
    int   n_vec = 0;
    int   n_mis = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference encoding from the plain rules: lowest set bit, popcount.
    function automatic ent_t encode(input logic [OW-1:0] w);
        ent_t e;
        int   ones = 0;
        e.bin = 0;
        for (int i = 0; i < OW; i++) begin
            if (w[i]) ones++;
        end
        for (int i = OW - 1; i >= 0; i--) begin
            if (w[i]) e.bin = i;
        end
        e.zero  = (ones == 0);
        e.multi = (ones > 1);
        return e;
    endfunction

    // Monitor + scoreboard: compare, then advance the model to the next edge.
    always @(negedge clk_i) begin
        ent_t hd;
        ent_t e;
        bit   acc;
        if (model_ok) begin
            chk("valid_o", valid_o, exp_q.size() > 0);
            chk("ready_o", ready_o, exp_q.size() < 2);
            hd = (exp_q.size() > 0) ? exp_q[0] : last_head;
            chk("bin_o", bin_o, hd.bin);
            chk("zero_o", zero_o, hd.zero);
            chk("multi_o", multi_o, hd.multi);
            chk("err_sticky_o", err_sticky_o, m_sticky);
`ifdef ONEHOT_TO_BIN_ERR_CNT_EN
            chk("err_cnt_o", err_cnt_o, m_cnt);
`else
            chk("err_cnt_o", err_cnt_o, 0);
`endif
        end
        if (rst_i) begin
            exp_q.delete();
            last_head = '{0, 1'b0, 1'b0};
            m_sticky  = 1'b0;
            m_cnt     = 0;
            model_ok  = 1'b1;
        end else if (model_ok) begin
            acc = valid_i && (exp_q.size() < 2);
            if (exp_q.size() > 0 && ready_i) last_head = exp_q.pop_front();
            if (clr_i) begin
                m_sticky = 1'b0;
                m_cnt    = 0;
            end
            if (acc) begin
                e = encode(onehot_i);
                exp_q.push_back(e);
                if (e.zero || e.multi) begin
                    m_sticky = 1'b1;
                    if (m_cnt < CNTMAX) m_cnt++;
                end
            end
        end
    end

    // Present a word and hold it until the block accepts it (bounded).
    task automatic send(input logic [OW-1:0] w);
        onehot_i = w;
        valid_i  = 1'b1;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk_i);
            if (ready_o) begin
                @(posedge clk_i);
                #1;
                valid_i = 1'b0;
                return;
            end
        end
        n_mis++;
        $display("FAIL send_timeout word %0h: ready_o stuck at %0b, required 1", w, ready_o);
        valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        valid_i = 1'b0;
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    function automatic logic [OW-1:0] rand_word();
        logic [OW-1:0] one;
        one = OW'(1);
        case ($urandom_range(0, 3))
            0:       return one << $urandom_range(0, OW - 1);
            1:       return '0;
            default: return OW'($urandom);
        endcase
    endfunction

    initial begin
        rst_i    = 1'b1;
        onehot_i = '0;
        valid_i  = 1'b0;
        ready_i  = 1'b1;
        clr_i    = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        idle(1);

        // Walking one, downstream always ready.
        for (int i = 0; i < OW; i++) begin
            logic [OW-1:0] w;
            w = OW'(1) << i;
            send(w);
        end
        idle(3);

        // Backpressure: queue fills, third word held until drain.
        ready_i = 1'b0;
        send(8'h04);
        send(8'h10);
        onehot_i = 8'h40;
        valid_i  = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        ready_i = 1'b1;
        send(8'h40);
        idle(4);

        // Zero and multi-hot words.
        send(8'h00);
        send(8'b0010_1000);
        idle(2);

        // Clear coinciding with an error push, then clear alone.
        clr_i = 1'b1;
        send(8'h00);
        clr_i = 1'b0;
        idle(2);
        clr_i = 1'b1;
        idle(1);
        clr_i = 1'b0;
        idle(2);

        // Run the error counter into saturation.
        for (int i = 0; i < 300; i++) begin
            send((i % 2 == 0) ? 8'h00 : 8'h03);
        end
        idle(3);
`ifdef ONEHOT_TO_BIN_ERR_CNT_EN
        chk("cnt_saturated", err_cnt_o, CNTMAX);
`endif

        // Reset with a full queue, then a fresh word.
        ready_i = 1'b0;
        send(8'h01);
        send(8'h02);
        rst_i   = 1'b1;
        valid_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i   = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b1;
        @(negedge clk_i);
        chk("post_rst_valid", valid_o, 0);
        chk("post_rst_ready", ready_o, 1);
        @(posedge clk_i);
        #1;
        send(8'h80);
        idle(3);

        // Random traffic with random backpressure and occasional clears.
        for (int i = 0; i < 600; i++) begin
            onehot_i = rand_word();
            valid_i  = ($urandom_range(0, 3) != 0);
            ready_i  = ($urandom_range(0, 2) != 0);
            clr_i    = ($urandom_range(0, 19) == 0);
            @(posedge clk_i);
            #1;
        end
        valid_i = 1'b0;
        clr_i   = 1'b0;
        ready_i = 1'b1;
        idle(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/onehot_to_bin_stream.md
Name: onehot_to_bin_stream

Overview:
- Parametrised, pipelined successor to the combinational one-hot-to-binary encoder.
- Accepts one-hot words over a valid/ready handshake and encodes each one to a binary index.
- Flags zero and multi-hot inputs and buffers results in a 2-entry output queue, so `ready_o` is registered.
- Sits between arbiter/grant logic and index-consuming datapaths that apply backpressure.

Parameters:
- `ONEHOT_WIDTH`, default 8: one-hot input width, ≥2.
- `BIN_WIDTH`, default `$clog2(ONEHOT_WIDTH)`: binary output width. Derived; do not override.
- `CNT_WIDTH`, default 8: width of the error counter (optional feature only).

Ports:
- `clk_i`  in  1  clock; all logic on rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `onehot_i`  in  ONEHOT_WIDTH  input word.
- `valid_i`  in  1  input word valid.
- `ready_o`  out  1  block can accept a word this cycle.
- `bin_o`  out  BIN_WIDTH  encoded index of the queue head.
- `zero_o`  out  1  head entry came from an all-zero input.
- `multi_o`  out  1  head entry came from an input with more than one bit set.
- `valid_o`  out  1  head entry valid.
- `ready_i`  in  1  downstream accepts the head.
- `clr_i`  in  1  clears the sticky error (and the counter, if present).
- `err_sticky_o`  out  1  an erroneous word has been accepted since the last reset/clear.
- `err_cnt_o`  out  CNT_WIDTH  saturating count of erroneous words. Tied to 0 without the macro.

Behaviour:
- Reset (`rst_i`=1 at an edge) clears everything:
  - queue empty, `valid_o`=0, `bin_o`=0, `zero_o`=0, `multi_o`=0
  - `ready_o`=1, `err_sticky_o`=0, `err_cnt_o`=0
  - Reset mid-transfer discards all queued entries; no partial output.
- Push: `valid_i && ready_o` at a rising edge.
- Pop: `valid_o && ready_i` at a rising edge.
- `ready_o` = (registered fill count < 2). It depends on no combinational input.
- Encoding, computed combinationally from `onehot_i` and stored at push:
  - `bin` = index of the lowest set bit (priority to LSB).
  - `zero` = (`onehot_i` == 0); `bin`=0 in that case.
  - `multi` = popcount(`onehot_i`) > 1.
  - Exactly one-hot input ⇒ `zero`=0, `multi`=0, `bin` = exact index.
- Latency: a word pushed at edge N into an empty queue drives `valid_o`=1 with its result during cycle N+1. No combinational path from input to output.
- Queue, 2 entries, FIFO order:
  - count 0: push → 1; no pop possible.
  - count 1: push only → 2; pop only → 0; push+pop → 1, new entry becomes head on the following cycle.
  - count 2: `ready_o`=0; `valid_i` is ignored and must be held by upstream; pop → 1.
- Head outputs (`bin_o`, `zero_o`, `multi_o`) are stable while `valid_o`=1 and `ready_i`=0.
- When the queue is empty, head outputs hold their last values; they are don't-care.
- Error word = pushed word with `zero` or `multi` set.
- `err_sticky_o`:
  - set at the edge an error word is pushed.
  - cleared by `clr_i`.
  - `clr_i` together with an error push ⇒ result is 1 (set wins).
- Errors are evaluated only on push; invalid cycles never set flags.

Optional Feature:
- Macro: `ONEHOT_TO_BIN_ERR_CNT_EN`.
- Defined:
  - `err_cnt_o` increments by 1 on each error push.
  - saturates at 2^CNT_WIDTH−1; no wrap.
  - `clr_i` clears it; `clr_i` with a simultaneous error push ⇒ 1.
- Undefined:
  - counter logic is not generated and `err_cnt_o` is tied to 0.
  - all other behaviour is identical.

Test Plan (ONEHOT_WIDTH=8, CNT_WIDTH=8):
1. Reset, `ready_i`=1, push 8'b0000_0001 … 8'b1000_0000 on consecutive cycles → `bin_o` 0…7, each one cycle after its push; `zero_o`=`multi_o`=0; `ready_o` stays 1; `err_sticky_o`=0.
2. `ready_i`=0, push 8'h04, 8'h10, 8'h40 back-to-back → third push not accepted (`ready_o`=0 after two pushes); head `bin_o`=2, held stable. Release `ready_i` → outputs 2, 4, then 6 once accepted; order preserved.
3. Push 8'h00 → `zero_o`=1, `bin_o`=0. Push 8'b0010_1000 → `multi_o`=1, `bin_o`=3. `err_sticky_o`=1 after the first of these; `err_cnt_o`=2 with the macro, 0 without.
4. Assert `clr_i` in the same cycle as pushing 8'h00 → `err_sticky_o`=1 and `err_cnt_o`=1 afterwards. `clr_i` alone → both 0.
5. With the macro, push 300 error words with `ready_i`=1 → `err_cnt_o` saturates at 255.
6. Fill the queue to 2 entries, assert `rst_i` for one cycle → `valid_o`=0, `ready_o`=1, `err_sticky_o`=0 the next cycle; the next pushed 8'h80 yields `bin_o`=7.
